// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data-memory accesses onto one single-port memory.
// Data side has priority; fetch is forced through after STARVE_MAX consecutive data wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [SW-1:0]     starve;
  logic              own_dm, acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              arb_ok, force_if, gnt_any, last_beat, busy;

  // Grants are held off while in reset so every output reads 0 during rst=0.
  assign arb_ok    = rst && (state != BUSY);
  assign force_if  = (starve == SW'(STARVE_MAX));
  assign if_gnt    = arb_ok && if_req && (!dm_req || force_if);
  assign dm_gnt    = arb_ok && dm_req && !(if_req && force_if);
  assign gnt_any   = if_gnt || dm_gnt;
  assign busy      = (state == BUSY);
  assign last_beat = busy && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = gnt_any ? BUSY : IDLE;
      BUSY:    state_nxt = last_beat ? DONE : BUSY;
      DONE:    state_nxt = gnt_any ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_valid  = (state == DONE) && !own_dm;
    dm_valid  = (state == DONE) && own_dm;
    mem_en    = busy;
    mem_we    = busy && acc_we;
    mem_addr  = busy ? acc_addr  : '0;
    mem_wdata = busy ? acc_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      own_dm    <= 1'b0;
      acc_we    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
      cnt       <= '0;
    end else if (gnt_any) begin
      own_dm    <= dm_gnt;
      acc_we    <= dm_gnt && dm_we;
      acc_addr  <= dm_gnt ? dm_addr : if_addr;
      acc_wdata <= dm_gnt ? dm_wdata : '0;
      cnt       <= CNT_W'(MEM_LAT - 1);
    end else if (busy && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Memory data is only valid in the final access cycle; writes leave rdata alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata <= '0;
      dm_rdata <= '0;
    end else if (last_beat && !acc_we) begin
      if (own_dm) dm_rdata <= mem_rdata;
      else        if_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 starve <= '0;
    else if (if_gnt)                          starve <= '0;
    else if (dm_gnt && if_req && !force_if)   starve <= starve + 1'b1;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level timing/data model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16, DATA_W = 16, MEM_LAT = 2, STARVE_MAX = 4;

  logic clk, rst;
  logic if_req, if_gnt, if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic dm_req, dm_we, dm_gnt, dm_valid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  int checks = 0, errors = 0;
  logic [15:0] exp_if_rdata, exp_dm_rdata;
  logic [15:0] ref_mem [0:4095];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h010) return 16'hABCD;
    return (16'(a) * 16'd40503) ^ 16'h5A5A;
  endfunction

  // Memory macro model: read data driven only in the last access cycle.
  bit [15:0] mem_arr [0:4095];
  bit        written [0:4095];
  int        bcnt = 0;
  always @(posedge clk) begin
    if (mem_en) bcnt <= bcnt + 1;
    else        bcnt <= 0;
    if (mem_en && mem_we && bcnt == MEM_LAT-1) begin
      mem_arr[mem_addr[11:0]] <= mem_wdata;
      written[mem_addr[11:0]] <= 1'b1;
    end
  end
  always_comb begin
    mem_rdata = 16'hDEAD;
    if (mem_en && !mem_we && bcnt == MEM_LAT-1)
      mem_rdata = written[mem_addr[11:0]] ? mem_arr[mem_addr[11:0]] : init_val(mem_addr[11:0]);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if_gnt, dm_gnt, if_valid, dm_valid, if_rdata, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got mem_en=%b if_rdata=%h dm_rdata=%h exp all zero", mem_en, if_rdata, dm_rdata);
    end
    dm_req = 1'b1; #1;
    checks++;
    if (dm_gnt !== 1'b0) begin errors++; $display("FAIL reset_no_gnt got %b exp 0", dm_gnt); end
    dm_req = 1'b0;
    rst = 1'b1;
    exp_if_rdata = 16'h0; exp_dm_rdata = 16'h0;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_idle_mem_en cyc %0d got %b exp 0", i, mem_en); end
    end
  endtask

  task automatic test_fetch_read;
    tick;
    if_req = 1'b1; if_addr = 16'h0010; #1;
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt got %b exp 1", if_gnt); end
    for (int c = 1; c <= 2; c++) begin
      tick; if_req = 1'b0;
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin
        errors++; $display("FAIL fetch_busy c%0d got en=%b we=%b addr=%h exp 1 0 0010", c, mem_en, mem_we, mem_addr);
      end
    end
    tick;
    exp_if_rdata = 16'hABCD;
    checks++;
    if ({if_valid, if_rdata, mem_en} !== {1'b1, 16'hABCD, 1'b0}) begin
      errors++; $display("FAIL fetch_valid got v=%b d=%h en=%b exp 1 abcd 0", if_valid, if_rdata, mem_en);
    end
  endtask

  task automatic test_simultaneous;
    tick;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0100; dm_wdata = 16'h0;
    if_req = 1'b1; if_addr = 16'h0020; #1;
    checks++;
    if ({dm_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL simul_gnt0 got dm=%b if=%b exp 1 0", dm_gnt, if_gnt); end
    tick; dm_req = 1'b0;
    checks++;
    if (if_gnt !== 1'b0) begin errors++; $display("FAIL simul_busy_gnt got %b exp 0", if_gnt); end
    tick; tick;
    exp_dm_rdata = ref_mem[12'h100];
    checks++;
    if ({dm_valid, dm_rdata, if_gnt} !== {1'b1, exp_dm_rdata, 1'b1}) begin
      errors++; $display("FAIL simul_done got v=%b d=%h ig=%b exp 1 %h 1", dm_valid, dm_rdata, if_gnt, exp_dm_rdata);
    end
    tick; if_req = 1'b0;
    tick; tick;
    exp_if_rdata = ref_mem[12'h020];
    checks++;
    if ({if_valid, if_rdata} !== {1'b1, exp_if_rdata}) begin
      errors++; $display("FAIL simul_if_valid got v=%b d=%h exp 1 %h", if_valid, if_rdata, exp_if_rdata);
    end
  endtask

  task automatic test_write_read;
    tick;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0200; dm_wdata = 16'h1234; #1;
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", dm_gnt); end
    for (int c = 1; c <= 2; c++) begin
      tick; dm_req = 1'b0;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0200, 16'h1234}) begin
        errors++; $display("FAIL wr_busy c%0d got en=%b we=%b a=%h d=%h exp 1 1 0200 1234", c, mem_en, mem_we, mem_addr, mem_wdata);
      end
    end
    tick;
    ref_mem[12'h200] = 16'h1234;
    checks++;
    if ({dm_valid, dm_rdata} !== {1'b1, exp_dm_rdata}) begin
      errors++; $display("FAIL wr_valid got v=%b d=%h exp 1 %h", dm_valid, dm_rdata, exp_dm_rdata);
    end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200; #1;
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt_in_done got %b exp 1", dm_gnt); end
    tick; dm_req = 1'b0;
    tick; tick;
    exp_dm_rdata = 16'h1234;
    checks++;
    if ({dm_valid, dm_rdata} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL rd_after_wr got v=%b d=%h exp 1 1234", dm_valid, dm_rdata);
    end
  endtask

  task automatic test_starvation;
    tick;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0040; if_req = 1'b1; if_addr = 16'h0030;
    for (int g = 0; g < 6; g++) begin
      logic exp_if;
      exp_if = (g == STARVE_MAX);
      #1;
      checks++;
      if ({if_gnt, dm_gnt} !== {exp_if, !exp_if}) begin
        errors++; $display("FAIL starve_grant%0d got if=%b dm=%b exp if=%b", g, if_gnt, dm_gnt, exp_if);
      end
      tick;
      if (g == 5) begin dm_req = 1'b0; if_req = 1'b0; end
      tick; tick;
    end
    exp_dm_rdata = ref_mem[12'h040];
    exp_if_rdata = ref_mem[12'h030];
  endtask

  task automatic test_reset_mid_access;
    tick;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0100; #1;
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt got %b exp 1", dm_gnt); end
    tick; dm_req = 1'b0;
    checks++;
    if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", mem_en); end
    #2 rst = 1'b0;
    #1;
    exp_dm_rdata = 16'h0; exp_if_rdata = 16'h0;
    checks++;
    if ({mem_en, mem_we, mem_addr, dm_valid, if_valid, dm_rdata, if_rdata} !== '0) begin
      errors++; $display("FAIL rstmid_async got en=%b dv=%b dd=%h id=%h exp all zero", mem_en, dm_valid, dm_rdata, if_rdata);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 2) rst = 1'b1;
      checks++;
      if ({dm_valid, mem_en} !== 2'b00) begin errors++; $display("FAIL rstmid_no_valid cyc %0d got v=%b en=%b exp 0 0", i, dm_valid, mem_en); end
    end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0020; #1;
    checks++;
    if (dm_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_regnt got %b exp 1", dm_gnt); end
    tick; dm_req = 1'b0;
    tick; tick;
    exp_dm_rdata = ref_mem[12'h020];
    checks++;
    if ({dm_valid, dm_rdata} !== {1'b1, exp_dm_rdata}) begin
      errors++; $display("FAIL rstmid_after got v=%b d=%h exp 1 %h", dm_valid, dm_rdata, exp_dm_rdata);
    end
  endtask

  // Model: one access at a time; grant at G, busy G+1..G+MEM_LAT, result at G+MEM_LAT+1.
  task automatic test_random(input int ncyc);
    int next_free = 0, vld_cyc = -1, gcyc = -100, starve = 0;
    bit ip = 0, dp = 0, ig_prev = 0, dg_prev = 0, own_dm = 0, a_we = 0;
    bit busy, free, exp_ig, exp_dg;
    logic [15:0] a_addr = '0, a_wdata = '0, a_data = '0;
    tick;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      if (!ip && !ig_prev && cyc < ncyc-15 && $urandom_range(1, 0) == 1) begin
        ip = 1; if_addr = 16'($urandom_range(4095, 0));
      end
      if (!dp && !dg_prev && cyc < ncyc-15 && $urandom_range(1, 0) == 1) begin
        dp = 1; dm_we = 1'($urandom_range(1, 0));
        dm_addr = 16'($urandom_range(4095, 0)); dm_wdata = 16'($urandom);
      end
      if_req = ip; dm_req = dp;
      #1;
      if (cyc == vld_cyc) begin
        if (!own_dm) exp_if_rdata = a_data;
        else if (!a_we) exp_dm_rdata = a_data;
      end
      checks++;
      if ({if_valid, dm_valid} !== {(cyc == vld_cyc) && !own_dm, (cyc == vld_cyc) && own_dm}) begin
        errors++; $display("FAIL rnd_valid cyc %0d got if=%b dm=%b exp owner_dm=%b at %0d", cyc, if_valid, dm_valid, own_dm, vld_cyc);
      end
      checks++;
      if ({if_rdata, dm_rdata} !== {exp_if_rdata, exp_dm_rdata}) begin
        errors++; $display("FAIL rnd_rdata cyc %0d got if=%h dm=%h exp if=%h dm=%h", cyc, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
      end
      busy = (cyc > gcyc) && (cyc <= gcyc + MEM_LAT);
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== {busy, busy && a_we, busy ? a_addr : 16'h0, busy ? a_wdata : 16'h0}) begin
        errors++; $display("FAIL rnd_mem cyc %0d got en=%b we=%b a=%h d=%h exp en=%b a=%h", cyc, mem_en, mem_we, mem_addr, mem_wdata, busy, a_addr);
      end
      free   = (cyc >= next_free);
      exp_ig = free && ip && (!dp || starve == STARVE_MAX);
      exp_dg = free && dp && !exp_ig;
      checks++;
      if ({if_gnt, dm_gnt} !== {exp_ig, exp_dg}) begin
        errors++; $display("FAIL rnd_gnt cyc %0d got if=%b dm=%b exp if=%b dm=%b", cyc, if_gnt, dm_gnt, exp_ig, exp_dg);
      end
      if (exp_ig || exp_dg) begin
        gcyc = cyc; next_free = cyc + MEM_LAT + 1; vld_cyc = next_free;
        own_dm = exp_dg; a_we = exp_dg && dm_we;
        a_addr = exp_dg ? dm_addr : if_addr;
        a_wdata = exp_dg ? dm_wdata : 16'h0;
        a_data = ref_mem[a_addr[11:0]];
        if (a_we) ref_mem[a_addr[11:0]] = dm_wdata;
        if (exp_ig) starve = 0;
        else if (ip && starve < STARVE_MAX) starve++;
      end
      ig_prev = exp_ig; dg_prev = exp_dg;
      if (exp_ig) ip = 0;
      if (exp_dg) dp = 0;
      tick;
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    test_reset;
    test_fetch_read;
    test_simultaneous;
    test_write_read;
    test_starvation;
    test_reset_mid_access;
    test_random(600);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
